// File: rtl/matmul_accel_param_pkg.sv
// Purpose: shared definitions for the matmul accelerator (FSM encoding, accumulator width, default bases).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMP,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [15:0] DEF_A_BASE = 16'h0000;
    localparam logic [15:0] DEF_B_BASE = 16'h0100;
    localparam logic [15:0] DEF_C_BASE = 16'h0000;

    // Full-precision dot-product width: product width plus growth for DIM terms.
    function automatic int acc_width(input int elem_w, input int dim);
        return 2 * elem_w + $clog2(dim);
    endfunction

endpackage

// File: rtl/matmul_accel_param_if.sv
// Purpose: memory/result-RAM bus and comp_enb/busyb/done handshake of the matmul accelerator.
// Latency: n/a (wiring only); mem_data is expected one cycle after mem_read_enb.
// Backpressure: none; the RAMs are assumed always ready.
// Ports: slave = accelerator side, master = host/RAM side.
interface matmul_accel_param_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
);
    logic              comp_enb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_read_enb;
    logic [ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0] res_data;
    logic              mem_write_enb;
    logic              busyb;
    logic              done;

    modport slave (
        input  comp_enb, mem_data,
        output mem_addr, mem_read_enb, res_addr, res_data, mem_write_enb, busyb, done
    );

    modport master (
        output comp_enb, mem_data,
        input  mem_addr, mem_read_enb, res_addr, res_data, mem_write_enb, busyb, done
    );
endinterface

// File: rtl/matmul_accel_param_mac_unit.sv
// Purpose: signed ELEM_W x ELEM_W multiply-accumulate with synchronous clear-and-load.
// Latency: 1 cycle (o_acc reflects the operands of the previous enabled cycle).
// Backpressure: none; i_en gates accumulation.
// Ports: clk, rst_n, i_en (accumulate), i_clr (start new sum), i_a/i_b operands, o_acc result.
module mac_unit #(
    parameter int ELEM_W = 16,
    parameter int ACC_W  = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic signed [ELEM_W-1:0] i_a,
    input  logic signed [ELEM_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);
    logic signed [2*ELEM_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod = i_a * i_b;

    // Clear and first product land in the same cycle, so a sum takes exactly DIM cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clr) r_acc <= ACC_W'(w_prod);
            else       r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/matmul_accel_param.sv
// Purpose: C = A x B for DIM x DIM signed matrices; loads A/B from input RAM, writes C to result RAM.
// Latency: done pulses 2*DIM^2+1+DIM^2*(DIM+1) cycles after the first read (113 for DIM=4).
// Backpressure: none; comp_enb rising edges are ignored while busyb=0.
// Ports: clk, rst_n, bus (slave modport: comp_enb, mem_*, res_*, busyb, done).
// Build option: MATMUL_SAT_EN clamps each result to OUT_W signed bits before the write.
module matmul_accel_param
    import matmul_pkg::*;
#(
    parameter int              DIM    = 4,
    parameter int              ELEM_W = 16,
    parameter int              DATA_W = 64,
    parameter int              ADDR_W = 16,
    parameter logic [ADDR_W-1:0] A_BASE = ADDR_W'(DEF_A_BASE),
    parameter logic [ADDR_W-1:0] B_BASE = ADDR_W'(DEF_B_BASE),
    parameter logic [ADDR_W-1:0] C_BASE = ADDR_W'(DEF_C_BASE),
    parameter int              OUT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    matmul_accel_param_if.slave    bus
);
    localparam int NN    = DIM * DIM;
    localparam int LD_N  = 2 * NN;
    localparam int LD_W  = $clog2(LD_N + 1);
    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int ACC_W = acc_width(ELEM_W, DIM);

    state_t r_state, w_next;

    logic                     r_comp_q;
    logic [LD_W-1:0]          r_ld_cnt, r_cap_idx;
    logic                     r_cap_vld;
    logic [IDX_W-1:0]         r_i, r_j, r_k;
    logic signed [ELEM_W-1:0] r_ab [LD_N];   // A at 0..NN-1, B at NN..2NN-1
    logic [ADDR_W-1:0]        r_rd_addr, r_wr_addr;
    logic [DATA_W-1:0]        r_wr_dat;

    logic                     w_start, w_ld_end, w_k_last, w_last;
    logic                     w_rd_en, w_wr_en, w_busyb, w_done;
    logic [ADDR_W-1:0]        w_rd_addr, w_wr_addr;
    int                       w_a_idx, w_b_idx;
    logic signed [ELEM_W-1:0] w_a, w_b;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [DATA_W-1:0] w_ext, w_res;

    assign w_start  = bus.comp_enb & ~r_comp_q;
    assign w_ld_end = (r_ld_cnt == LD_W'(LD_N));
    assign w_k_last = (r_k == IDX_W'(DIM - 1));
    assign w_last   = (r_i == IDX_W'(DIM - 1)) && (r_j == IDX_W'(DIM - 1));

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        w_busyb = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busyb = 1'b1;
                if (w_start) w_next = ST_LOAD;
            end
            // One extra LOAD cycle after the last read lets the final B word be captured.
            ST_LOAD: begin
                w_rd_en = ~w_ld_end;
                if (w_ld_end) w_next = ST_COMP;
            end
            ST_COMP: begin
                if (w_k_last) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_wr_en = 1'b1;
                w_next  = w_last ? ST_DONE : ST_COMP;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_rd_addr = (r_ld_cnt < LD_W'(NN)) ? A_BASE + ADDR_W'(r_ld_cnt)
                                              : B_BASE + ADDR_W'(r_ld_cnt - LD_W'(NN));
    assign w_wr_addr = C_BASE + ADDR_W'(32'(r_i) * 32'(DIM) + 32'(r_j));

    assign w_a_idx = int'(r_i) * DIM + int'(r_k);
    assign w_b_idx = int'(r_k) * DIM + int'(r_j);

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int n = 0; n < NN; n++) begin
            if (n == w_a_idx) w_a = r_ab[n];
            if (n == w_b_idx) w_b = r_ab[NN + n];
        end
    end

    mac_unit #(.ELEM_W(ELEM_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_state == ST_COMP),
        .i_clr (r_k == '0),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_acc (w_acc)
    );

    assign w_ext = DATA_W'(w_acc);

`ifdef MATMUL_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = ~SAT_MAX;
    assign w_res = (w_ext > SAT_MAX) ? SAT_MAX : (w_ext < SAT_MIN) ? SAT_MIN : w_ext;
`else
    assign w_res = w_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_comp_q  <= 1'b0;
            r_ld_cnt  <= '0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_dat  <= '0;
        end else begin
            r_state   <= w_next;
            r_comp_q  <= bus.comp_enb;
            r_cap_vld <= w_rd_en;
            r_cap_idx <= r_ld_cnt;

            if (r_state == ST_LOAD) begin
                if (!w_ld_end) r_ld_cnt <= r_ld_cnt + 1'b1;
            end else begin
                r_ld_cnt <= '0;
            end

            if (r_state == ST_COMP) r_k <= w_k_last ? '0 : r_k + 1'b1;
            else                    r_k <= '0;

            if (r_state == ST_IDLE) begin
                r_i <= '0;
                r_j <= '0;
            end else if (r_state == ST_WRITE) begin
                if (r_j == IDX_W'(DIM - 1)) begin
                    r_j <= '0;
                    r_i <= r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end

            if (w_rd_en) r_rd_addr <= w_rd_addr;
            if (w_wr_en) begin
                r_wr_addr <= w_wr_addr;
                r_wr_dat  <= w_res;
            end
        end
    end

    // Read data arrives the cycle after its address; r_cap_idx is that address's load index.
    always_ff @(posedge clk) begin
        if (r_cap_vld) begin
            for (int n = 0; n < LD_N; n++) begin
                if (r_cap_idx == LD_W'(n)) r_ab[n] <= bus.mem_data[ELEM_W-1:0];
            end
        end
    end

    // Strobes follow the state; addr/data hold their last driven value between phases.
    assign bus.mem_read_enb  = w_rd_en;
    assign bus.mem_addr      = w_rd_en ? w_rd_addr : r_rd_addr;
    assign bus.mem_write_enb = w_wr_en;
    assign bus.res_addr      = w_wr_en ? w_wr_addr : r_wr_addr;
    assign bus.res_data      = w_wr_en ? w_res : r_wr_dat;
    assign bus.busyb         = w_busyb;
    assign bus.done          = w_done;
endmodule

// File: tb/tb_matmul_accel_param.sv
// Purpose: directed self-checking bench for matmul_accel_param (DIM=4 and DIM=1 instances).
// Latency: checks done at cycle 113 (DIM=4) and 5 (DIM=1) after the first read strobe.
// Backpressure: RAM models always ready; read data returned one cycle after the strobe.
module tb_matmul_accel_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matmul_accel_param_if #(.ADDR_W(16), .DATA_W(64)) bus4 ();
    matmul_accel_param_if #(.ADDR_W(16), .DATA_W(64)) bus1 ();

    matmul_accel_param #(.DIM(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    matmul_accel_param #(.DIM(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [63:0] mem4 [512];
    logic [63:0] mem1 [512];
    logic [63:0] res4 [16];
    logic [63:0] res1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int rd4 = 0, wr4 = 0, done4 = 0, start4 = 0, donec4 = 0, bad4 = 0;
    int rd1 = 0, wr1 = 0, done1 = 0, start1 = 0, donec1 = 0, bad1 = 0;

    always @(posedge clk) begin
        if (bus4.mem_read_enb) bus4.mem_data <= mem4[bus4.mem_addr[8:0]];
        if (bus1.mem_read_enb) bus1.mem_data <= mem1[bus1.mem_addr[8:0]];
    end

    always @(negedge clk) begin
        cyc++;
        if (bus4.mem_read_enb) begin
            if (rd4 == 0) start4 = cyc;
            rd4++;
        end
        if (bus4.mem_write_enb) begin
            wr4++;
            if (bus4.res_addr < 16) res4[bus4.res_addr[3:0]] = bus4.res_data;
            else bad4++;
        end
        if (bus4.mem_read_enb && bus4.mem_write_enb) bad4++;
        if (bus4.done) begin
            done4++;
            donec4 = cyc;
        end
        if (bus1.mem_read_enb) begin
            if (rd1 == 0) start1 = cyc;
            rd1++;
        end
        if (bus1.mem_write_enb) begin
            wr1++;
            if (bus1.res_addr == 0) res1 = bus1.res_data;
            else bad1++;
        end
        if (bus1.mem_read_enb && bus1.mem_write_enb) bad1++;
        if (bus1.done) begin
            done1++;
            donec1 = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear4();
        rd4 = 0; wr4 = 0; done4 = 0; start4 = 0; donec4 = 0; bad4 = 0;
        for (int n = 0; n < 16; n++) res4[n] = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic pulse4();
        bus4.comp_enb = 1'b1;
        tick();
        bus4.comp_enb = 1'b0;
    endtask

    task automatic wait_done4(input int target, input string name);
        int n = 0;
        while (done4 < target && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (done4 < target) begin
            n_fail++;
            $display("FAIL %s timeout: done pulses %0d, required %0d", name, done4, target);
        end
    endtask

    task automatic load_identity(input int b_off);
        for (int n = 0; n < 16; n++) begin
            mem4[n]         = (n / 4 == n % 4) ? 64'd1 : 64'd0;
            mem4[256 + n]   = 64'(b_off + n + 1);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (bus4.busyb !== 1'b1)         begin n_fail++; $display("FAIL rst_busyb: got %b want 1", bus4.busyb); end
        n_checks++; if (bus4.done !== 1'b0)          begin n_fail++; $display("FAIL rst_done: got %b want 0", bus4.done); end
        n_checks++; if (bus4.mem_read_enb !== 1'b0)  begin n_fail++; $display("FAIL rst_rd: got %b want 0", bus4.mem_read_enb); end
        n_checks++; if (bus4.mem_write_enb !== 1'b0) begin n_fail++; $display("FAIL rst_wr: got %b want 0", bus4.mem_write_enb); end
        n_checks++; if (bus4.mem_addr !== 16'h0)     begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", bus4.mem_addr); end
        n_checks++; if (bus4.res_addr !== 16'h0)     begin n_fail++; $display("FAIL rst_res_addr: got %h want 0", bus4.res_addr); end
        n_checks++; if (bus4.res_data !== 64'h0)     begin n_fail++; $display("FAIL rst_res_data: got %h want 0", bus4.res_data); end
        n_checks++; if (bus1.busyb !== 1'b1)         begin n_fail++; $display("FAIL rst_busyb1: got %b want 1", bus1.busyb); end
    endtask

    task automatic test_identity();
        load_identity(0);
        clear4();
        pulse4();
        wait_done4(1, "identity");
        tick();
        for (int n = 0; n < 16; n++) begin
            n_checks++;
            if (res4[n] !== 64'(n + 1)) begin
                n_fail++; $display("FAIL ident_C%0d: got %h want %h", n, res4[n], 64'(n + 1));
            end
        end
        n_checks++; if (donec4 - start4 !== 113) begin n_fail++; $display("FAIL ident_done_cycle: got %0d want 113", donec4 - start4); end
        n_checks++; if (wr4 !== 16) begin n_fail++; $display("FAIL ident_writes: got %0d want 16", wr4); end
        n_checks++; if (rd4 !== 32) begin n_fail++; $display("FAIL ident_reads: got %0d want 32", rd4); end
        n_checks++; if (bad4 !== 0) begin n_fail++; $display("FAIL ident_strobe_addr: got %0d bad events want 0", bad4); end
        n_checks++; if (done4 !== 1) begin n_fail++; $display("FAIL ident_done_count: got %0d want 1", done4); end
        n_checks++; if (bus4.busyb !== 1'b1) begin n_fail++; $display("FAIL ident_busyb_after: got %b want 1", bus4.busyb); end
    endtask

    task automatic test_max();
        logic [63:0] exp;
`ifdef MATMUL_SAT_EN
        exp = 64'h0000_0000_7FFF_FFFF;
`else
        exp = 64'h0000_0000_FFFC_0004;
`endif
        for (int n = 0; n < 16; n++) begin
            mem4[n]       = 64'h0000_0000_0000_7FFF;
            mem4[256 + n] = 64'h0000_0000_0000_7FFF;
        end
        clear4();
        pulse4();
        wait_done4(1, "max");
        for (int n = 0; n < 16; n++) begin
            n_checks++;
            if (res4[n] !== exp) begin n_fail++; $display("FAIL max_C%0d: got %h want %h", n, res4[n], exp); end
        end
        n_checks++; if (donec4 - start4 !== 113) begin n_fail++; $display("FAIL max_done_cycle: got %0d want 113", donec4 - start4); end
    endtask

    task automatic test_signed();
        for (int n = 0; n < 16; n++) begin
            mem4[n]       = 64'hA5A5_5A5A_0000_0000;
            mem4[256 + n] = 64'h1234_0000_0000_0000;
        end
        mem4[0]   = 64'h1234_5678_9ABC_FFFD;
        mem4[256] = 64'h0000_0000_0000_0005;
        clear4();
        pulse4();
        wait_done4(1, "signed");
        n_checks++;
        if (res4[0] !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            n_fail++; $display("FAIL signed_C0: got %h want FFFFFFFFFFFFFFF1", res4[0]);
        end
        for (int n = 1; n < 16; n++) begin
            n_checks++;
            if (res4[n] !== 64'h0) begin n_fail++; $display("FAIL signed_C%0d: got %h want 0", n, res4[n]); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        load_identity(0);
        clear4();
        pulse4();
        while ((rd4 == 0 || cyc - start4 < 49) && n < 200) begin
            tick();
            n++;
        end
        n_checks++; if (wr4 !== 3) begin n_fail++; $display("FAIL midrst_writes_before: got %0d want 3", wr4); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus4.busyb !== 1'b1)         begin n_fail++; $display("FAIL midrst_busyb: got %b want 1", bus4.busyb); end
        n_checks++; if (bus4.mem_write_enb !== 1'b0) begin n_fail++; $display("FAIL midrst_wr: got %b want 0", bus4.mem_write_enb); end
        n_checks++; if (bus4.res_addr !== 16'h0)     begin n_fail++; $display("FAIL midrst_res_addr: got %h want 0", bus4.res_addr); end
        n_checks++; if (bus4.res_data !== 64'h0)     begin n_fail++; $display("FAIL midrst_res_data: got %h want 0", bus4.res_data); end
        n_checks++; if (bus4.mem_addr !== 16'h0)     begin n_fail++; $display("FAIL midrst_mem_addr: got %h want 0", bus4.mem_addr); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        n_checks++; if (wr4 !== 3) begin n_fail++; $display("FAIL midrst_writes_after: got %0d want 3", wr4); end
        load_identity(100);
        clear4();
        pulse4();
        wait_done4(1, "midrst_rerun");
        for (int m = 0; m < 16; m++) begin
            n_checks++;
            if (res4[m] !== 64'(m + 101)) begin n_fail++; $display("FAIL midrst_C%0d: got %h want %h", m, res4[m], 64'(m + 101)); end
        end
        n_checks++; if (donec4 - start4 !== 113) begin n_fail++; $display("FAIL midrst_done_cycle: got %0d want 113", donec4 - start4); end
    endtask

    task automatic test_level_hold();
        load_identity(0);
        clear4();
        bus4.comp_enb = 1'b1;
        repeat (200) tick();
        n_checks++; if (done4 !== 1) begin n_fail++; $display("FAIL hold_done_count: got %0d want 1", done4); end
        n_checks++; if (rd4 !== 32)  begin n_fail++; $display("FAIL hold_reads: got %0d want 32", rd4); end
        n_checks++; if (bus4.busyb !== 1'b1) begin n_fail++; $display("FAIL hold_busyb: got %b want 1", bus4.busyb); end
        bus4.comp_enb = 1'b0;
        repeat (2) tick();
        pulse4();
        wait_done4(2, "second_edge");
        n_checks++; if (rd4 !== 64) begin n_fail++; $display("FAIL second_reads: got %0d want 64", rd4); end
        n_checks++; if (res4[15] !== 64'd16) begin n_fail++; $display("FAIL second_C15: got %h want 10", res4[15]); end
    endtask

    task automatic test_dim1();
        int n = 0;
        mem1[0]   = 64'h0000_0000_0000_0007;
        mem1[256] = 64'hFFFF_FFFF_FFFF_FFFE;
        res1 = 64'hBAD0_BAD0_BAD0_BAD0;
        rd1 = 0; wr1 = 0; done1 = 0; bad1 = 0;
        bus1.comp_enb = 1'b1;
        tick();
        bus1.comp_enb = 1'b0;
        while (done1 == 0 && n < 50) begin
            tick();
            n++;
        end
        n_checks++; if (done1 !== 1) begin n_fail++; $display("FAIL dim1_done_count: got %0d want 1", done1); end
        n_checks++; if (res1 !== 64'hFFFF_FFFF_FFFF_FFF2) begin n_fail++; $display("FAIL dim1_C: got %h want FFFFFFFFFFFFFFF2", res1); end
        n_checks++; if (donec1 - start1 !== 5) begin n_fail++; $display("FAIL dim1_done_cycle: got %0d want 5", donec1 - start1); end
        n_checks++; if (wr1 !== 1) begin n_fail++; $display("FAIL dim1_writes: got %0d want 1", wr1); end
        n_checks++; if (rd1 !== 2) begin n_fail++; $display("FAIL dim1_reads: got %0d want 2", rd1); end
        n_checks++; if (bad1 !== 0) begin n_fail++; $display("FAIL dim1_strobe_addr: got %0d want 0", bad1); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus4.comp_enb = 1'b0;
        bus1.comp_enb = 1'b0;
        bus4.mem_data = '0;
        bus1.mem_data = '0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        repeat (2) tick();
        test_identity();
        tick();
        test_max();
        tick();
        test_signed();
        tick();
        test_reset_mid();
        tick();
        test_level_hold();
        tick();
        test_dim1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
